// File: rtl/pdp8_tt_pkg.sv
// rtl/pdp8_tt_pkg.sv - shared constants, IOT pulse decode and tx FSM encoding for pdp8_tt_multi
package pdp8_tt_pkg;

  localparam logic [3:0] ST_F0 = 4'd0;
  localparam logic [3:0] ST_F1 = 4'd1;
  localparam logic [3:0] ST_F2 = 4'd2;
  localparam logic [3:0] ST_F3 = 4'd3;

  localparam int IOT_P1 = 0;
  localparam int IOT_P2 = 1;
  localparam int IOT_P4 = 2;

  localparam logic [1:0] TX_ST_IDLE  = 2'd0;
  localparam logic [1:0] TX_ST_SEND  = 2'd1;
  localparam logic [1:0] TX_ST_DELAY = 2'd2;

  typedef struct packed {
    logic p4;
    logic p2;
    logic p1;
  } iot_pulse_t;

  function automatic iot_pulse_t iot_decode(input logic [2:0] pulses);
    iot_pulse_t p;
    p.p1 = pulses[IOT_P1];
    p.p2 = pulses[IOT_P2];
    p.p4 = pulses[IOT_P4];
    return p;
  endfunction

endpackage

// File: rtl/pdp8_tt_multi_if.sv
// rtl/pdp8_tt_multi_if.sv - CPU IOT bus plus host rx/tx character streams for pdp8_tt_multi
interface pdp8_tt_multi_if #(
  parameter int DATA_W = 8
);
  logic              iot;
  logic [3:0]        state;
  logic [11:0]       mb;
  logic [5:0]        io_select;
  logic [11:0]       io_data_in;
  logic [11:0]       io_data_out;
  logic              io_selected;
  logic              io_data_avail;
  logic              io_interrupt;
  logic              io_skip;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_char;
  logic              rx_ready;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_char;
  logic              tx_ready;

  modport master (
    output iot, state, mb, io_select, io_data_in, rx_valid, rx_char, tx_ready,
    input  io_data_out, io_selected, io_data_avail, io_interrupt, io_skip,
           rx_ready, tx_valid, tx_char
  );

  modport slave (
    input  iot, state, mb, io_select, io_data_in, rx_valid, rx_char, tx_ready,
    output io_data_out, io_selected, io_data_avail, io_interrupt, io_skip,
           rx_ready, tx_valid, tx_char
  );
endinterface

// File: rtl/pdp8_tt_rxfifo.sv
// rtl/pdp8_tt_rxfifo.sv - keyboard receive buffer; RX_DEPTH entries with TT_RX_FIFO_EN, else one holding register
module pdp8_tt_rxfifo #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

`ifdef TT_RX_FIFO_EN
  localparam int DEPTH = RX_DEPTH;
`else
  // RX_DEPTH has no effect here; the buffer is a single holding register.
  localparam int DEPTH = (RX_DEPTH > 0) ? 1 : 1;
`endif
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_next(wr_q);
      end
      if (do_pop) begin
        rd_q <= ptr_next(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pdp8_tt_multi.sv
// rtl/pdp8_tt_multi.sv - KL8E-style keyboard/printer IOT decoder with host streams
// Optional TT_RX_FIFO_EN selects a multi-entry receive FIFO (handled in pdp8_tt_rxfifo).
module pdp8_tt_multi
  import pdp8_tt_pkg::*;
#(
  parameter logic [5:0] RX_DEV   = 6'o03,
  parameter logic [5:0] TX_DEV   = 6'o04,
  parameter int         DATA_W   = 8,
  parameter int         TX_DELAY = 20,
  parameter int         RX_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  pdp8_tt_multi_if.slave   bus
);

  localparam int CNT_W = (TX_DELAY < 1) ? 1 : $clog2(TX_DELAY + 1);

  iot_pulse_t        p;
  logic              f1_iot, rx_hit, tx_hit;
  logic              rx_push, rx_pop, rx_empty, rx_full, rx_flag;
  logic [DATA_W-1:0] rx_head;
  logic [11:0]       head_ext;
  logic              unused_mb;

  logic [1:0]        tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_char_q, tx_char_d;
  logic              tx_flag_q, tx_flag_d;
  logic              int_en_q, int_en_d;

  logic              io_selected, io_skip;
  logic [11:0]       io_data_out;

  assign p         = iot_decode(bus.mb[2:0]);
  assign unused_mb = ^bus.mb[11:3];
  assign f1_iot    = bus.iot && (bus.state == ST_F1);
  assign rx_hit    = f1_iot && (bus.io_select == RX_DEV);
  assign tx_hit    = f1_iot && (bus.io_select == TX_DEV);

  assign rx_push   = bus.rx_valid && !rx_full;
  assign rx_pop    = rx_hit && p.p2;
  assign rx_flag   = !rx_empty;
  assign head_ext  = 12'(rx_head);

  pdp8_tt_rxfifo #(
    .DATA_W   (DATA_W),
    .RX_DEPTH (RX_DEPTH)
  ) u_rxfifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rx_push),
    .push_data_i (bus.rx_char),
    .pop_i       (rx_pop),
    .head_o      (rx_head),
    .empty_o     (rx_empty),
    .full_o      (rx_full)
  );

  always_comb begin
    io_selected = 1'b0;
    io_skip     = 1'b0;
    io_data_out = bus.io_data_in;
    if (rx_hit) begin
      io_selected = 1'b1;
      if (p.p1 && !p.p4) io_skip = rx_flag;
      if (p.p4 && p.p2) begin
        io_data_out = head_ext;
      end else if (p.p4 && !p.p1) begin
        io_data_out = bus.io_data_in | head_ext;
      end else if (p.p2 && !p.p1 && !p.p4) begin
        io_data_out = '0;
      end
    end else if (tx_hit) begin
      io_selected = 1'b1;
      if (p.p1) io_skip = tx_flag_q;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    cnt_d      = cnt_q;
    tx_char_d  = tx_char_q;
    tx_flag_d  = tx_flag_q;
    int_en_d   = int_en_q;

    if (rx_hit && p.p1 && p.p4 && !p.p2) int_en_d = bus.io_data_in[0];
    if (tx_hit && !p.p1 && !p.p2 && !p.p4) tx_flag_d = 1'b1;
    if (tx_hit && p.p2) tx_flag_d = 1'b0;

    // Flag-only IOTs never disturb a character already handed to the host.
    case (tx_state_q)
      TX_ST_IDLE: begin
        if (tx_hit && p.p4) begin
          tx_char_d  = bus.io_data_in[DATA_W-1:0];
          tx_state_d = TX_ST_SEND;
        end
      end
      TX_ST_SEND: begin
        if (bus.tx_ready) begin
          cnt_d      = CNT_W'(TX_DELAY);
          tx_state_d = TX_ST_DELAY;
        end
      end
      TX_ST_DELAY: begin
        if (bus.state == ST_F3) begin
          if (cnt_q == '0) begin
            tx_flag_d  = 1'b1;
            tx_state_d = TX_ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: tx_state_d = TX_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_ST_IDLE;
      cnt_q      <= '0;
      tx_char_q  <= '0;
      tx_flag_q  <= 1'b0;
      int_en_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      cnt_q      <= cnt_d;
      tx_char_q  <= tx_char_d;
      tx_flag_q  <= tx_flag_d;
      int_en_q   <= int_en_d;
    end
  end

  assign bus.io_selected   = io_selected;
  assign bus.io_skip       = io_skip;
  assign bus.io_data_out   = io_data_out;
  assign bus.io_data_avail = 1'b1;
  assign bus.io_interrupt  = int_en_q && (rx_flag || tx_flag_q);
  assign bus.rx_ready      = !rx_full;
  assign bus.tx_valid      = (tx_state_q == TX_ST_SEND);
  assign bus.tx_char       = tx_char_q;

endmodule

// File: tb/tb_pdp8_tt_multi.sv
// tb/tb_pdp8_tt_multi.sv - scoreboard bench for pdp8_tt_multi (adapts to TT_RX_FIFO_EN)
module tb_pdp8_tt_multi;
  import pdp8_tt_pkg::*;

`ifdef TT_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [11:0] dout;
  logic        skip, sel;

  pdp8_tt_multi_if #(.DATA_W(8)) bus();

  pdp8_tt_multi #(
    .RX_DEV   (6'o03),
    .TX_DEV   (6'o04),
    .DATA_W   (8),
    .TX_DELAY (20),
    .RX_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic iot_op(input logic [5:0] dev, input logic [2:0] op, input logic [11:0] ac);
    @(negedge clk);
    bus.iot        = 1'b1;
    bus.state      = ST_F1;
    bus.io_select  = dev;
    bus.mb         = {3'o6, dev, op};
    bus.io_data_in = ac;
    #1;
    dout = bus.io_data_out;
    skip = bus.io_skip;
    sel  = bus.io_selected;
    @(negedge clk);
    bus.iot        = 1'b0;
    bus.state      = ST_F0;
    bus.io_data_in = '0;
    #1;
  endtask

  task automatic f3_cycles(input int n);
    @(negedge clk);
    bus.state = ST_F3;
    repeat (n) @(posedge clk);
    @(negedge clk);
    bus.state = ST_F0;
    #1;
  endtask

  task automatic rx_push(input logic [7:0] ch);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_char  = ch;
    #1;
    check("rx_push_ready", bus.rx_ready, 1);
    if (bus.rx_ready) rx_q.push_back(ch);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
  endtask

  task automatic tx_accept();
    @(negedge clk);
    bus.tx_ready = 1'b1;
    #1;
    check("tx_valid_at_accept", bus.tx_valid, 1);
    check("tx_sb_nonempty", tx_q.size() != 0, 1);
    if (bus.tx_valid && tx_q.size() != 0) check("tx_char", bus.tx_char, tx_q.pop_front());
    @(negedge clk);
    bus.tx_ready = 1'b0;
    #1;
    check("tx_valid_after_accept", bus.tx_valid, 0);
  endtask

  initial begin
    logic [7:0] ch;
    logic       acc;

    bus.iot = 1'b0; bus.state = ST_F0; bus.mb = '0; bus.io_select = '0;
    bus.io_data_in = '0; bus.rx_valid = 1'b0; bus.rx_char = '0; bus.tx_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_char", bus.tx_char, 0);
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_irq", bus.io_interrupt, 0);
    check("data_avail", bus.io_data_avail, 1);
    bus.io_data_in = 12'o1234;
    #1;
    check("idle_passthru", bus.io_data_out, 12'o1234);
    check("idle_sel", bus.io_selected, 0);
    bus.io_data_in = '0;

    iot_op(6'o04, 3'o1, 12'o0);
    check("tsf_sel", sel, 1);
    check("tsf_skip_rst", skip, 0);
    check("tsf_irq_rst", bus.io_interrupt, 0);

    // Printer: load, stall host, accept, count delay states
    iot_op(6'o04, 3'o6, 12'o0101);
    tx_q.push_back(8'h41);
    check("tx_valid_load", bus.tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("tx_hold", bus.tx_valid, 1);
    end
    tx_accept();
    iot_op(6'o04, 3'o4, 12'o0132);
    check("tx_load_busy_valid", bus.tx_valid, 0);
    check("tx_load_busy_char", bus.tx_char, 8'h41);
    f3_cycles(20);
    check("tx_delay_20", bus.io_interrupt, 0);
    f3_cycles(1);
    check("tx_delay_21", bus.io_interrupt, 1);
    iot_op(6'o04, 3'o1, 12'o0);
    check("tsf_skip_set", skip, 1);
    iot_op(6'o04, 3'o2, 12'o0);
    check("tcf_irq", bus.io_interrupt, 0);
    iot_op(6'o04, 3'o1, 12'o0);
    check("tsf_skip_clr", skip, 0);
    iot_op(6'o04, 3'o0, 12'o0);
    check("tfl_irq", bus.io_interrupt, 1);
    iot_op(6'o04, 3'o2, 12'o0);
    check("tfl_tcf_irq", bus.io_interrupt, 0);

    // Keyboard: fill until back-pressure
    for (int i = 0; i < RX_CAP + 1; i++) begin
      ch = 8'(8'h41 + i);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_char  = ch;
      #1;
      check("rx_ready_fill", bus.rx_ready, (i < RX_CAP) ? 1 : 0);
      if (bus.rx_ready) rx_q.push_back(ch);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("rx_count", rx_q.size(), RX_CAP);
    iot_op(6'o03, 3'o1, 12'o0);
    check("ksf_skip_full", skip, 1);
    iot_op(6'o03, 3'o4, 12'o7400);
    check("krs_or", dout, 12'o7400 | {4'b0, rx_q[0]});
    for (int i = 0; i < RX_CAP; i++) begin
      iot_op(6'o03, 3'o6, 12'o7777);
      check("krb", dout, {4'b0, rx_q.pop_front()});
    end
    iot_op(6'o03, 3'o1, 12'o0);
    check("ksf_skip_empty", skip, 0);
    check("rx_ready_empty", bus.rx_ready, 1);

    rx_push(8'h45);
    iot_op(6'o03, 3'o2, 12'o5555);
    check("kcc_zero", dout, 0);
    void'(rx_q.pop_front());
    iot_op(6'o03, 3'o1, 12'o0);
    check("kcc_popped", skip, 0);

    // KRB together with a host push in the same cycle
    rx_push(8'h46);
    @(negedge clk);
    bus.iot = 1'b1; bus.state = ST_F1; bus.io_select = 6'o03; bus.mb = 12'o6036;
    bus.io_data_in = '0; bus.rx_valid = 1'b1; bus.rx_char = 8'h47;
    #1;
    check("krb_simul", bus.io_data_out, {4'b0, rx_q.pop_front()});
    acc = bus.rx_ready;
    check("rx_ready_simul", acc, (RX_CAP > 1) ? 1 : 0);
    if (acc) rx_q.push_back(8'h47);
    @(negedge clk);
    bus.iot = 1'b0; bus.state = ST_F0; bus.rx_valid = 1'b0;
    iot_op(6'o03, 3'o1, 12'o0);
    check("ksf_after_simul", skip, (rx_q.size() != 0) ? 1 : 0);
    for (int i = 0; i < RX_CAP; i++) begin
      if (rx_q.size() != 0) begin
        iot_op(6'o03, 3'o6, 12'o0);
        check("krb_drain", dout, {4'b0, rx_q.pop_front()});
      end
    end

    // Pop on an empty buffer must not disturb it
    iot_op(6'o03, 3'o2, 12'o0);
    check("empty_pop_ready", bus.rx_ready, 1);
    check("empty_pop_irq", bus.io_interrupt, 0);
    rx_push(8'h48);
    iot_op(6'o03, 3'o6, 12'o0);
    check("krb_after_empty_pop", dout, {4'b0, rx_q.pop_front()});

    // KIE
    rx_push(8'h49);
    iot_op(6'o03, 3'o5, 12'o0);
    check("kie_dout0", dout, 12'o0);
    check("kie_noskip", skip, 0);
    check("kie_irq_off", bus.io_interrupt, 0);
    iot_op(6'o03, 3'o5, 12'o7001);
    check("kie_dout1", dout, 12'o7001);
    check("kie_irq_on", bus.io_interrupt, 1);

    // Reset in the middle of a printer delay with receive data held
    if (RX_CAP > 1) rx_push(8'h4A);
    iot_op(6'o03, 3'o5, 12'o0);
    iot_op(6'o04, 3'o4, 12'o0105);
    tx_q.push_back(8'h45);
    tx_accept();
    check("tx_sb_drained", tx_q.size(), 0);
    f3_cycles(3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    tx_q.delete();
    #1;
    check("rst2_tx_valid", bus.tx_valid, 0);
    check("rst2_tx_char", bus.tx_char, 0);
    check("rst2_rx_ready", bus.rx_ready, 1);
    check("rst2_irq", bus.io_interrupt, 0);
    iot_op(6'o03, 3'o1, 12'o0);
    check("rst2_rx_flag", skip, 0);
    iot_op(6'o04, 3'o1, 12'o0);
    check("rst2_tx_flag", skip, 0);
    iot_op(6'o04, 3'o0, 12'o0);
    check("rst2_int_en", bus.io_interrupt, 1);
    iot_op(6'o04, 3'o2, 12'o0);
    f3_cycles(25);
    check("rst2_delay_aborted", bus.io_interrupt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
